spi_flash_xip_line: RTL

APB-slave SPI-flash execute-in-place (XIP) read engine with a built-in SPI mode-0 shifter and a single-line prefetch buffer. Successor to the APB/SPI XIP bridge: parametrised in divider, read command, chip select and line size. It fetches a whole LINE_WORDS-word line per flash READ and serves sequential reads in the same line from the buffer. It sits on the APB fabric at the flash window and drives the flash pins directly.

---
 rtl/spi_flash_xip_line.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spi_flash_xip_line.sv
// APB-slave SPI-flash XIP read engine: mode-0 shifter with a one-line prefetch buffer.
module spi_flash_xip_line #(
  parameter logic [31:0] FLASH_ADDR_START = 32'h3000_0000,
  parameter logic [31:0] FLASH_ADDR_END   = 32'h3fff_ffff,
  parameter int unsigned SS_NUM           = 8,
  parameter int unsigned SS_IDX           = 0,
  parameter int unsigned SCK_DIV          = 0,
  parameter logic [7:0]  READ_CMD         = 8'h03,
  parameter int unsigned LINE_WORDS       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       in_paddr,
  input  logic              in_psel,
  input  logic              in_penable,
  input  logic [2:0]        in_pprot,
  input  logic              in_pwrite,
  input  logic [31:0]       in_pwdata,
  input  logic [3:0]        in_pstrb,
  output logic              in_pready,
  output logic [31:0]       in_prdata,
  output logic              in_pslverr,
  input  logic              xip_flush,
  output logic              spi_sck,
  output logic [SS_NUM-1:0] spi_ss,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned OFF_W     = $clog2(4 * LINE_WORDS);
  localparam int unsigned TAG_W     = 24 - OFF_W;
  localparam int unsigned LINE_BITS = 32 * LINE_WORDS;
  localparam int unsigned LIDX_W    = $clog2(LINE_BITS);
  localparam int unsigned NBITS     = 32 + LINE_BITS;
  localparam int unsigned BC_W      = $clog2(NBITS);
  localparam int unsigned DIV_W     = $clog2(SCK_DIV + 2);
  localparam logic [SS_NUM-1:0] SS_SEL = ~(SS_NUM'(1) << SS_IDX);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP, ERR} state_t;

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic [31:0]          hdr_sh;
  logic [TAG_W-1:0]     tag_q;
  logic                 valid;
  logic [3:0]           widx;
  logic [LINE_BITS-1:0] line_q;

  logic                 req;
  logic                 in_win;
  logic                 hit;
  logic [TAG_W-1:0]     req_tag;
  logic [3:0]           req_widx;
  logic [3:0]           sel_widx;
  logic [31:0]          word_sel;
  logic [LIDX_W-1:0]    cap_idx;
  logic                 unused_apb;

  assign req      = in_psel & in_penable;
  assign in_win   = (in_paddr >= FLASH_ADDR_START) && (in_paddr <= FLASH_ADDR_END);
  assign req_tag  = in_paddr[23:OFF_W];
  assign hit      = valid & ~xip_flush & (tag_q == req_tag);
  assign req_widx = 4'((in_paddr >> 2) & 32'(LINE_WORDS - 1));
  assign sel_widx = (state == IDLE) ? req_widx : widx;
  // Data bit j lands at (j ^ 7): bytes fill little-endian within a word, bits arrive MSB first.
  assign cap_idx  = LIDX_W'((32'(bit_cnt) - 32'd32) ^ 32'd7);
  assign unused_apb = ^{in_pprot, in_pwdata, in_pstrb};

  // Select the requested word out of the line buffer.
  always_comb begin
    word_sel = '0;
    for (int unsigned w = 0; w < LINE_WORDS; w++) begin
      if (sel_widx == 4'(w)) word_sel = line_q[w*32 +: 32];
    end
  end

  // Request decode, SPI bit engine, line fill and APB response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      hdr_sh     <= '0;
      tag_q      <= '0;
      valid      <= 1'b0;
      widx       <= '0;
      line_q     <= '0;
      spi_sck    <= 1'b0;
      spi_ss     <= '1;
      spi_mosi   <= 1'b0;
      in_pready  <= 1'b0;
      in_pslverr <= 1'b0;
      in_prdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (in_pwrite || !in_win) begin
              state      <= ERR;
              in_pready  <= 1'b1;
              in_pslverr <= 1'b1;
              in_prdata  <= '0;
            end else if (hit) begin
              state     <= RESP;
              in_pready <= 1'b1;
              in_prdata <= word_sel;
            end else begin
              state    <= SHIFT;
              valid    <= 1'b0;
              tag_q    <= req_tag;
              widx     <= req_widx;
              hdr_sh   <= {READ_CMD, req_tag, OFF_W'(0)};
              spi_mosi <= READ_CMD[7];
              spi_ss   <= SS_SEL;
              spi_sck  <= 1'b0;
              bit_cnt  <= '0;
              div_cnt  <= '0;
            end
          end
        end
        SHIFT: begin
          if (div_cnt != DIV_W'(SCK_DIV)) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              if (bit_cnt >= BC_W'(32)) line_q[cap_idx] <= spi_miso;
            end else if (bit_cnt == BC_W'(NBITS - 1)) begin
              spi_sck   <= 1'b0;
              spi_ss    <= '1;
              spi_mosi  <= 1'b0;
              valid     <= 1'b1;
              state     <= RESP;
              in_pready <= 1'b1;
              in_prdata <= word_sel;
            end else begin
              spi_sck  <= 1'b0;
              bit_cnt  <= bit_cnt + 1'b1;
              spi_mosi <= hdr_sh[30];
              hdr_sh   <= {hdr_sh[30:0], 1'b0};
            end
          end
        end
        RESP, ERR: begin
          state      <= IDLE;
          in_pready  <= 1'b0;
          in_pslverr <= 1'b0;
          in_prdata  <= '0;
        end
        default: state <= IDLE;
      endcase
      // A flush always wins over a line becoming valid on the same edge.
      if (xip_flush) valid <= 1'b0;
    end
  end

endmodule
